// File: rtl/pipe_pkg.sv
// Shared encodings for the execute stage: ALU op codes, mul/div op codes,
// MDU state encoding and a small magnitude helper.
package pipe_pkg;

    // ALU op low three bits; ealuc[3] only distinguishes sra from srl
    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b100;
    localparam logic [2:0] ALUC_AND = 3'b001;
    localparam logic [2:0] ALUC_OR  = 3'b101;
    localparam logic [2:0] ALUC_XOR = 3'b010;
    localparam logic [2:0] ALUC_LUI = 3'b110;
    localparam logic [2:0] ALUC_SLL = 3'b011;
    localparam logic [2:0] ALUC_SRX = 3'b111;

    localparam logic [2:0] MDOP_NONE  = 3'd0;
    localparam logic [2:0] MDOP_MULT  = 3'd1;
    localparam logic [2:0] MDOP_MULTU = 3'd2;
    localparam logic [2:0] MDOP_DIV   = 3'd3;
    localparam logic [2:0] MDOP_DIVU  = 3'd4;
    localparam logic [2:0] MDOP_MFHI  = 3'd5;
    localparam logic [2:0] MDOP_MFLO  = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    function automatic logic [31:0] mag(input logic [31:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

endpackage

// File: rtl/pipeexe_md_if.sv
// D/E-side inputs and E/M-side outputs of the execute stage.
interface pipeexe_md_if;
    logic [3:0]  ealuc;
    logic        ealuimm;
    logic        eshift;
    logic        ejal;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] eimm;
    logic [31:0] epc4;
    logic [4:0]  ern0;
    logic [2:0]  emdop;
    logic [31:0] ealu;
    logic [4:0]  ern;
    logic        estall;
    logic [31:0] ehi;
    logic [31:0] elo;

    modport master (
        output ealuc, ealuimm, eshift, ejal, ea, eb, eimm, epc4, ern0, emdop,
        input  ealu, ern, estall, ehi, elo
    );

    modport slave (
        input  ealuc, ealuimm, eshift, ejal, ea, eb, eimm, epc4, ern0, emdop,
        output ealu, ern, estall, ehi, elo
    );
endinterface

// File: rtl/pipemdu.sv
// Iterative multiply/divide unit: one bit per cycle, HI/LO registers,
// stall generation for the upstream pipeline.
module pipemdu
    import pipe_pkg::*;
#(
    parameter int MD_ITERS = 32
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [2:0]  emdop,
    input  logic [31:0] ea,
    input  logic [31:0] eb,
    output logic        estall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int CW = (MD_ITERS > 1) ? $clog2(MD_ITERS) : 1;

    mdu_state_t  state;
    logic [CW-1:0] cnt;
    logic        is_div;
    logic        neg_q;     // negate product / quotient
    logic        neg_r;     // negate remainder (dividend sign)
    logic        dz;
    logic [31:0] a_raw;
    logic [31:0] m;         // multiplicand or divisor magnitude
    logic [63:0] acc;       // mult: partial product; div: {rem, quotient}

    logic        start, sgn, sa, sb, div_op;
    logic [31:0] ma, mb;
    logic [32:0] msum, dtry;
    logic        ge;
    logic [63:0] acc_nx, prod;
    logic [31:0] q_f, r_f, hi_f, lo_f;

    assign start  = emdop inside {MDOP_MULT, MDOP_MULTU, MDOP_DIV, MDOP_DIVU};
    assign sgn    = (emdop == MDOP_MULT) || (emdop == MDOP_DIV);
    assign div_op = (emdop == MDOP_DIV) || (emdop == MDOP_DIVU);
    assign sa     = sgn & ea[31];
    assign sb     = sgn & eb[31];
    assign ma     = mag(ea, sa);
    assign mb     = mag(eb, sb);

    assign estall = ((state == IDLE) && start) || (state == BUSY);

    // Shift-add multiply step and restoring shift-subtract divide step
    always_comb begin
        msum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, m} : 33'd0);
        ge   = {acc[63:32], acc[31]} >= {1'b0, m};
        dtry = {acc[63:32], acc[31]} - {1'b0, m};
        if (is_div)
            acc_nx = {(ge ? dtry[31:0] : {acc[62:32], acc[31]}), acc[30:0], ge};
        else
            acc_nx = {msum, acc[31:1]};
    end

    always_comb begin
        prod = neg_q ? -acc_nx : acc_nx;
        q_f  = mag(acc_nx[31:0], neg_q);
        r_f  = mag(acc_nx[63:32], neg_r);
        if (!is_div) begin
            hi_f = prod[63:32];
            lo_f = prod[31:0];
        end else if (dz) begin
            hi_f = a_raw;
            lo_f = 32'hFFFF_FFFF;
        end else begin
            hi_f = r_f;
            lo_f = q_f;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            a_raw  <= '0;
            m      <= '0;
            acc    <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state  <= BUSY;
                    cnt    <= CW'(MD_ITERS - 1);
                    is_div <= div_op;
                    neg_q  <= sa ^ sb;
                    neg_r  <= sa;
                    dz     <= (eb == 32'd0);
                    a_raw  <= ea;
                    m      <= div_op ? mb : ma;
                    acc    <= {32'd0, div_op ? ma : mb};
                end
                BUSY: begin
                    acc <= acc_nx;
                    if (cnt == '0) begin
                        hi    <= hi_f;
                        lo    <= lo_f;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pipeexe_md.sv
// Execute stage: combinational ALU, jal link / MFHI / MFLO result select,
// destination select, and the iterative mul/div unit.
module pipeexe_md
    import pipe_pkg::*;
#(
    parameter int MD_ITERS = 32
) (
    input  logic       clock,
    input  logic       resetn,
    pipeexe_md_if.slave bus
);
    logic [31:0] opa, opb, alu;

    assign opa = bus.eshift  ? {27'd0, bus.eimm[10:6]} : bus.ea;
    assign opb = bus.ealuimm ? bus.eimm : bus.eb;

    always_comb begin
        case (bus.ealuc[2:0])
            ALUC_ADD: alu = opa + opb;
            ALUC_SUB: alu = opa - opb;
            ALUC_AND: alu = opa & opb;
            ALUC_OR:  alu = opa | opb;
            ALUC_XOR: alu = opa ^ opb;
            ALUC_LUI: alu = {opb[15:0], 16'd0};
            ALUC_SLL: alu = opb << opa[4:0];
            ALUC_SRX: alu = bus.ealuc[3] ? 32'($signed(opb) >>> opa[4:0])
                                         : opb >> opa[4:0];
            default:  alu = opa + opb;
        endcase
    end

    always_comb begin
        if (bus.ejal)                    bus.ealu = bus.epc4 + 32'd4;
        else if (bus.emdop == MDOP_MFHI) bus.ealu = bus.ehi;
        else if (bus.emdop == MDOP_MFLO) bus.ealu = bus.elo;
        else                             bus.ealu = alu;
    end

    assign bus.ern = bus.ejal ? 5'd31 : bus.ern0;

    pipemdu #(.MD_ITERS(MD_ITERS)) u_mdu (
        .clock  (clock),
        .resetn (resetn),
        .emdop  (bus.emdop),
        .ea     (bus.ea),
        .eb     (bus.eb),
        .estall (bus.estall),
        .hi     (bus.ehi),
        .lo     (bus.elo)
    );

endmodule

// File: tb/tb_pipeexe_md.sv
// Directed bench for the execute stage; mul/div results go through a scoreboard queue.
module tb_pipeexe_md;
    import pipe_pkg::*;

    localparam int MD_ITERS = 32;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    pipeexe_md_if bus ();
    pipeexe_md #(.MD_ITERS(MD_ITERS)) dut (.clock(clock), .resetn(resetn), .bus(bus));

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          stall;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
        exp_t e;
        int n;
        sb.push_back('{hi, lo, MD_ITERS + 1});
        bus.emdop = op; bus.ea = a; bus.eb = b;
        #1;
        n = 0;
        for (int i = 0; i < 100 && bus.estall; i++) begin
            n++;
            tick();
        end
        e = sb.pop_front();
        chk({tag, "_stall_cycles"}, 32'(n), 32'(e.stall));
        chk({tag, "_hi"}, bus.ehi, e.hi);
        chk({tag, "_lo"}, bus.elo, e.lo);
        bus.emdop = MDOP_NONE;
        tick();
    endtask

    initial begin
        bus.ealuc = 4'd0; bus.ealuimm = 1'b0; bus.eshift = 1'b0; bus.ejal = 1'b0;
        bus.ea = '0; bus.eb = '0; bus.eimm = '0; bus.epc4 = '0; bus.ern0 = '0;
        bus.emdop = MDOP_NONE;
        #2;
        chk("rst_ealu", bus.ealu, 32'd0);
        chk("rst_ern", {27'd0, bus.ern}, 32'd0);
        chk("rst_estall", {31'd0, bus.estall}, 32'd0);
        chk("rst_hi", bus.ehi, 32'd0);
        chk("rst_lo", bus.elo, 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        bus.ea = 32'd7; bus.eb = 32'd5; bus.ealuc = 4'b0000; #1;
        chk("add", bus.ealu, 32'd12);
        chk("add_estall", {31'd0, bus.estall}, 32'd0);
        bus.ealuc = 4'b0100; #1;
        chk("sub", bus.ealu, 32'd2);
        bus.ealuc = 4'b0101; #1;
        chk("or", bus.ealu, 32'd7);
        bus.ealuimm = 1'b1; bus.eimm = 32'h0000_1234; bus.ealuc = 4'b0110; #1;
        chk("lui", bus.ealu, 32'h1234_0000);
        bus.ealuimm = 1'b0;

        bus.eshift = 1'b1; bus.eimm = 32'd4 << 6; bus.eb = 32'h8000_0000;
        bus.ealuc = 4'b1111; #1;
        chk("sra", bus.ealu, 32'hF800_0000);
        bus.ealuc = 4'b0111; #1;
        chk("srl", bus.ealu, 32'h0800_0000);
        bus.ealuc = 4'b0011; bus.eb = 32'h0000_0003; #1;
        chk("sll", bus.ealu, 32'h0000_0030);
        bus.eshift = 1'b0;

        bus.ejal = 1'b1; bus.epc4 = 32'h0000_0040; bus.ern0 = 5'd0; #1;
        chk("jal_ealu", bus.ealu, 32'h0000_0044);
        chk("jal_ern", {27'd0, bus.ern}, 32'd31);
        bus.ejal = 1'b0; bus.ern0 = 5'd9; #1;
        chk("ern_pass", {27'd0, bus.ern}, 32'd9);

        bus.emdop = 3'd7; #1;
        chk("reserved_no_stall", {31'd0, bus.estall}, 32'd0);
        bus.emdop = MDOP_NONE;
        tick();

        run_md("mult", MDOP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_md("multu", MDOP_MULTU, 32'hFFFF_FFFD, 32'd5, 32'd4, 32'hFFFF_FFF1);
        bus.emdop = MDOP_MFLO; #1;
        chk("mflo", bus.ealu, 32'hFFFF_FFF1);
        bus.emdop = MDOP_MFHI; #1;
        chk("mfhi", bus.ealu, 32'd4);
        bus.emdop = MDOP_NONE;
        tick();

        run_md("div", MDOP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divu", MDOP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        run_md("div_ovf", MDOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_md("divu_zero", MDOP_DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF);

        // Reset in the middle of a MULT
        bus.emdop = MDOP_MULT; bus.ea = 32'd3; bus.eb = 32'd3;
        for (int i = 0; i < 11; i++) tick();
        chk("busy_stall", {31'd0, bus.estall}, 32'd1);
        resetn = 1'b0; bus.emdop = MDOP_NONE; #1;
        chk("midrst_estall", {31'd0, bus.estall}, 32'd0);
        chk("midrst_hi", bus.ehi, 32'd0);
        chk("midrst_lo", bus.elo, 32'd0);
        chk("midrst_idle", {30'd0, dut.u_mdu.state}, {30'd0, IDLE});
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("postrst_no_stall", {31'd0, bus.estall}, 32'd0);
        run_md("postrst_multu", MDOP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
